// File: rtl/order_ram_pkg.sv
// Shared constants, state encoding and parity helper
// for the dual-port order-content store.
package order_ram_pkg;

    localparam int ORDER_DATA_W = 976;
    localparam int ORDER_ADDR_W = 12;

    // Widest word the parity helper accepts; narrower
    // words are zero-extended, which leaves parity unchanged.
    localparam int PAR_MAX_W = 4096;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic even_parity(
        input logic [PAR_MAX_W-1:0] d
    );
        return ^d;
    endfunction

endpackage

// File: rtl/order_ram_clear_ctrl.sv
// Clear engine: walks every address writing zeros, then
// reports ready. Ports: clk, reset, clear_req -> clr_we, clr_addr, init_done.
module order_ram_clear_ctrl
    import order_ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = ORDER_ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= addr_nxt;
        end
    end

    // reset gates the outputs so nothing is written or
    // accepted while the block is held in reset.
    always_comb begin
        state_nxt = state;
        addr_nxt  = clr_addr;
        clr_we    = 1'b0;
        init_done = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                clr_we   = ~reset;
                addr_nxt = clr_addr + 1'b1;
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                init_done = ~reset;
                if (clear_req) begin
                    state_nxt = ST_CLEAR;
                    addr_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/order_content_ram_dp.sv
// Dual-port order-content RAM: port A read/write, port B read-only,
// built-in clear engine, registered outputs with valid strobes.
// Ports: clk, reset; a_en/a_we/a_addr/a_din -> a_dout/a_dout_valid;
// b_en/b_addr -> b_dout/b_dout_valid; clear_req -> init_done;
// a_parity_err/b_parity_err (live only with ORDER_RAM_PARITY_EN defined).
module order_content_ram_dp
    import order_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = ORDER_DATA_W,
    parameter int ADDR_WIDTH     = ORDER_ADDR_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    output logic                  a_dout_valid,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_dout_valid,
    input  logic                  clear_req,
    output logic                  init_done,
    output logic                  a_parity_err,
    output logic                  b_parity_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef ORDER_RAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int STORE_W = DATA_WIDTH + PAR_W;

    (* ram_style = "block" *)
    logic [STORE_W-1:0] ram [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  acc_a;
    logic                  acc_b;
    logic                  a_wr;
    logic                  fwd;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [STORE_W-1:0]    wr_word;
    logic [STORE_W-1:0]    a_rd;
    logic [STORE_W-1:0]    b_rd;

    order_ram_clear_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET != 0)
    ) u_clear (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    assign acc_a = init_done & a_en;
    assign acc_b = init_done & b_en;
    assign a_wr  = acc_a & a_we;
    // B reading the word A is writing gets the new data.
    assign fwd   = a_wr & acc_b & (a_addr == b_addr);

    // One shared write port: clear and A never overlap.
    always_comb begin
        wr_en   = clr_we | a_wr;
        wr_addr = a_addr;
        wr_word = '0;
        if (clr_we) begin
            wr_addr = clr_addr;
        end else begin
`ifdef ORDER_RAM_PARITY_EN
            wr_word = {even_parity(PAR_MAX_W'(a_din)), a_din};
`else
            wr_word = a_din;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_word;
        end
    end

    assign a_rd = ram[a_addr];
    assign b_rd = ram[b_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout       <= '0;
            b_dout       <= '0;
            a_dout_valid <= 1'b0;
            b_dout_valid <= 1'b0;
        end else begin
            a_dout_valid <= acc_a;
            b_dout_valid <= acc_b;
            if (acc_a) begin
                a_dout <= a_we ? a_din : a_rd[DATA_WIDTH-1:0];
            end
            if (acc_b) begin
                b_dout <= fwd ? a_din : b_rd[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef ORDER_RAM_PARITY_EN
    // A stored word with even parity XORs to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_parity_err <= 1'b0;
            b_parity_err <= 1'b0;
        end else begin
            a_parity_err <= acc_a & ~a_we & (^a_rd);
            b_parity_err <= acc_b & ~fwd & (^b_rd);
        end
    end
`else
    assign a_parity_err = 1'b0;
    assign b_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_order_content_ram_dp.sv
// Randomised scoreboard bench for order_content_ram_dp
// against an array-based reference model.
module tb_order_content_ram_dp;

    localparam int DW    = 976;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_en;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic [DW-1:0] a_dout;
    logic          a_dout_valid;
    logic          b_en;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_dout;
    logic          b_dout_valid;
    logic          clear_req;
    logic          init_done;
    logic          a_parity_err;
    logic          b_parity_err;

    order_content_ram_dp #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .a_en         (a_en),
        .a_we         (a_we),
        .a_addr       (a_addr),
        .a_din        (a_din),
        .a_dout       (a_dout),
        .a_dout_valid (a_dout_valid),
        .b_en         (b_en),
        .b_addr       (b_addr),
        .b_dout       (b_dout),
        .b_dout_valid (b_dout_valid),
        .clear_req    (clear_req),
        .init_done    (init_done),
        .a_parity_err (a_parity_err),
        .b_parity_err (b_parity_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    bit            bad [DEPTH];
    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] last_a;
    logic [DW-1:0] last_b;
    bit            model_ready = 1'b0;
    int            clr_left = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input bit ok,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h want %h (low 256 bits)",
                     nm, act[255:0], exp[255:0]);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [1023:0] t;
        for (int i = 0; i < 32; i++) t[i*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            bad[i] = 1'b0;
        end
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic step(input logic ae, input logic we,
                        input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad,
                        input logic be, input logic [AW-1:0] ba,
                        input logic cr);
        a_en = ae; a_we = we; a_addr = aa; a_din = ad;
        b_en = be; b_addr = ba; clear_req = cr;
        if (model_ready) begin
            if (ae) begin
                if (we) qa.push_back('{ad, 1'b0});
                else    qa.push_back('{mem[aa], bad[aa]});
            end
            if (be) begin
                if (ae && we && aa == ba) qb.push_back('{ad, 1'b0});
                else                      qb.push_back('{mem[ba], bad[ba]});
            end
            if (ae && we) begin
                mem[aa] = ad;
                bad[aa] = 1'b0;
            end
            if (cr) begin
                model_ready = 1'b0;
                clr_left = DEPTH;
                model_zero();
            end
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) model_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic rand_step(input int amax, input int clr_pct);
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, amax)), rnd(),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, amax)),
             1'($urandom_range(0, 99) < clr_pct));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        a_en = 0; a_we = 0; b_en = 0; clear_req = 0;
        a_addr = '0; b_addr = '0; a_din = '0;
        model_ready = 1'b0;
        last_a = '0;
        last_b = '0;
        qa.delete();
        qb.delete();
        model_zero();
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        clr_left = DEPTH;
    endtask

    task automatic wait_ready(input int exp, input string nm);
        int n = 0;
        while (!init_done && n < 3 * DEPTH) begin
            rand_step(DEPTH - 1, 10);
            n++;
        end
        chk(nm, n == exp, DW'(n), DW'(exp));
    endtask

    always @(posedge clk) begin
        bit   have;
        exp_t e;
        #1;
        chk("init_done", init_done == model_ready,
            DW'(init_done), DW'(model_ready));

        have = qa.size() != 0;
        if (a_dout_valid || have) begin
            if (have) e = qa.pop_front();
            chk("a_valid", a_dout_valid == have,
                DW'(a_dout_valid), DW'(have));
            if (have && a_dout_valid) begin
                chk("a_dout", a_dout == e.d, a_dout, e.d);
                chk("a_perr", a_parity_err == e.pe,
                    DW'(a_parity_err), DW'(e.pe));
                last_a = e.d;
            end
        end else begin
            chk("a_hold", a_dout == last_a && !a_parity_err,
                a_dout, last_a);
        end

        have = qb.size() != 0;
        if (b_dout_valid || have) begin
            if (have) e = qb.pop_front();
            chk("b_valid", b_dout_valid == have,
                DW'(b_dout_valid), DW'(have));
            if (have && b_dout_valid) begin
                chk("b_dout", b_dout == e.d, b_dout, e.d);
                chk("b_perr", b_parity_err == e.pe,
                    DW'(b_parity_err), DW'(e.pe));
                last_b = e.d;
            end
        end else begin
            chk("b_hold", b_dout == last_b && !b_parity_err,
                b_dout, last_b);
        end
    end

    initial begin
        do_reset(3);
        wait_ready(DEPTH, "rise_after_reset");

        // cleared table reads zero at the ends and middle
        step(1, 0, AW'(0), '0, 1, AW'(2047), 0);
        step(1, 0, AW'(4095), '0, 1, AW'(0), 0);
        step(1, 0, AW'(2047), '0, 1, AW'(4095), 0);
        idle();

        // write then read back on both ports
        step(1, 1, AW'(5), DW'(16'hABCD), 0, '0, 0);
        step(1, 0, AW'(5), '0, 0, '0, 0);
        step(0, 0, '0, '0, 1, AW'(5), 0);
        idle();

        // same-address collision forwards new data to B
        step(1, 1, AW'(9), DW'(8'h77), 0, '0, 0);
        step(1, 1, AW'(9), DW'(16'h1234), 1, AW'(9), 0);
        idle();
        step(0, 0, '0, '0, 1, AW'(9), 0);
        idle();

        // clear request together with an access
        step(1, 1, AW'(100), DW'(8'hFF), 0, '0, 0);
        step(1, 0, AW'(100), '0, 1, AW'(100), 1);
        wait_ready(DEPTH, "clear_len");
        step(1, 0, AW'(100), '0, 1, AW'(100), 0);
        idle();

        // reset part-way through a clear restarts it
        step(0, 0, '0, '0, 0, '0, 1);
        repeat (1000) rand_step(DEPTH - 1, 10);
        do_reset(2);
        wait_ready(DEPTH, "rise_after_mid_reset");

        // random traffic on a small window to hit collisions
        repeat (3000) rand_step(15, 0);
        idle();

`ifdef ORDER_RAM_PARITY_EN
        step(1, 1, AW'(7), rnd(), 0, '0, 0);
        step(1, 1, AW'(8), rnd(), 0, '0, 0);
        dut.ram[7][0] = ~dut.ram[7][0];
        mem[7][0] = ~mem[7][0];
        bad[7] = 1'b1;
        step(0, 0, '0, '0, 1, AW'(7), 0);
        step(1, 0, AW'(7), '0, 1, AW'(8), 0);
        idle();
`endif

        idle();
        chk("qa_drained", qa.size() == 0, DW'(qa.size()), '0);
        chk("qb_drained", qb.size() == 0, DW'(qb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
